// File: rtl/xif_result_stage_if.sv
// Signal bundle between the custom execute stage, the X-IF commit stream and the X-IF result channel.
// Names follow the result stage's point of view: *_i are driven into the stage, *_o are driven by it.
interface xif_result_stage_if #(
   parameter int DEPTH      = 4,
   parameter int ID_WIDTH   = 4,
   parameter int DATA_WIDTH = 32
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic                  ex_valid_i;
   logic                  ex_ready_o;
   logic [ID_WIDTH-1:0]   ex_id_i;
   logic [4:0]            ex_rd_i;
   logic [DATA_WIDTH-1:0] ex_data_i;
   logic                  ex_we_i;

   logic                  commit_valid_i;
   logic [ID_WIDTH-1:0]   commit_id_i;
   logic                  commit_kill_i;

   logic                  result_valid_o;
   logic                  result_ready_i;
   logic [ID_WIDTH-1:0]   result_id_o;
   logic [4:0]            result_rd_o;
   logic [DATA_WIDTH-1:0] result_data_o;
   logic                  result_we_o;

   logic [CNT_W-1:0]      count_o;

   modport master (
      output ex_valid_i, ex_id_i, ex_rd_i, ex_data_i, ex_we_i,
      output commit_valid_i, commit_id_i, commit_kill_i,
      output result_ready_i,
      input  ex_ready_o, result_valid_o, result_id_o, result_rd_o, result_data_o, result_we_o,
      input  count_o
   );

   modport slave (
      input  ex_valid_i, ex_id_i, ex_rd_i, ex_data_i, ex_we_i,
      input  commit_valid_i, commit_id_i, commit_kill_i,
      input  result_ready_i,
      output ex_ready_o, result_valid_o, result_id_o, result_rd_o, result_data_o, result_we_o,
      output count_o
   );
endinterface

// File: rtl/xif_result_stage.sv
// In-order result buffer behind the custom execute stage; releases each result on the X-IF result
// channel once its id has been committed, and discards it once its id has been killed.
module xif_result_stage #(
   parameter int DEPTH      = 4,
   parameter int ID_WIDTH   = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic               clk_i,
   input  logic               rst_i,
   xif_result_stage_if.slave  xif
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int TBL   = 2 ** ID_WIDTH;

   logic [ID_WIDTH-1:0]   mem_id   [DEPTH];
   logic [4:0]            mem_rd   [DEPTH];
   logic [DATA_WIDTH-1:0] mem_data [DEPTH];
   logic                  mem_we   [DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [TBL-1:0]   cmt_q, cmt_d, kill_q, kill_d;

   logic [ID_WIDTH-1:0] head_id;
   logic empty, full, head_cmt, res_valid, drop, pop, push;
   logic commit_live, dup_push;

   // Head status comes only from registered state, so result_ready_i never reaches result_valid_o.
   assign head_id   = mem_id[rd_ptr_q];
   assign empty     = (count_q == '0);
   assign full      = (count_q == CNT_W'(DEPTH));
   assign head_cmt  = !empty && cmt_q[head_id];
   assign res_valid = head_cmt && !kill_q[head_id];
   assign drop      = head_cmt && kill_q[head_id];
   assign pop       = (res_valid && xif.result_ready_i) || drop;
   assign push      = xif.ex_valid_i && !full;

   assign xif.ex_ready_o     = !full;
   assign xif.count_o        = count_q;
   assign xif.result_valid_o = res_valid;
   assign xif.result_id_o    = res_valid ? head_id           : '0;
   assign xif.result_rd_o    = res_valid ? mem_rd[rd_ptr_q]   : '0;
   assign xif.result_data_o  = res_valid ? mem_data[rd_ptr_q] : '0;
   assign xif.result_we_o    = res_valid ? mem_we[rd_ptr_q]   : 1'b0;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      cmt_d    = cmt_q;
      kill_d   = kill_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (!push && pop) count_d = count_q - CNT_W'(1);
      if (pop) begin
         cmt_d[head_id]  = 1'b0;
         kill_d[head_id] = 1'b0;
      end
      // A new commit for the id being retired this cycle must survive, so the set comes last.
      if (xif.commit_valid_i) begin
         cmt_d[xif.commit_id_i]  = 1'b1;
         kill_d[xif.commit_id_i] = xif.commit_kill_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         cmt_q    <= '0;
         kill_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         cmt_q    <= cmt_d;
         kill_q   <= kill_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_id[wr_ptr_q]   <= xif.ex_id_i;
         mem_rd[wr_ptr_q]   <= xif.ex_rd_i;
         mem_data[wr_ptr_q] <= xif.ex_data_i;
         mem_we[wr_ptr_q]   <= xif.ex_we_i;
      end
   end

   // Protocol checks: an id may not be committed twice while live, nor pushed twice while buffered.
   assign commit_live = cmt_q[xif.commit_id_i] && !(pop && head_id == xif.commit_id_i);

   always_comb begin
      dup_push = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (CNT_W'(i) < count_q && mem_id[rd_ptr_q + PTR_W'(i)] == xif.ex_id_i && !(i == 0 && pop))
            dup_push = 1'b1;
      end
   end

   a_commit_live : assert property (@(posedge clk_i) disable iff (rst_i)
      !(xif.commit_valid_i && commit_live));
   a_dup_push : assert property (@(posedge clk_i) disable iff (rst_i)
      !(push && dup_push));

endmodule

// File: tb/tb_xif_result_stage.sv
// Directed bench for xif_result_stage: each cycle drives one stimulus vector and compares the
// result channel and occupancy against hand-computed values.
module tb_xif_result_stage;
   localparam int DEPTH      = 4;
   localparam int ID_WIDTH   = 4;
   localparam int DATA_WIDTH = 32;

   logic clk = 1'b0;
   logic rst;
   int   vectors     = 0;
   int   miscompares = 0;

   xif_result_stage_if #(.DEPTH(DEPTH), .ID_WIDTH(ID_WIDTH), .DATA_WIDTH(DATA_WIDTH)) xif ();

   xif_result_stage #(.DEPTH(DEPTH), .ID_WIDTH(ID_WIDTH), .DATA_WIDTH(DATA_WIDTH)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .xif   (xif)
   );

   always #5 clk = ~clk;

   task automatic applyStimulus(input logic ex_v, input logic [ID_WIDTH-1:0] id, input logic [4:0] rd,
                                input logic [DATA_WIDTH-1:0] data, input logic we,
                                input logic c_v, input logic [ID_WIDTH-1:0] c_id, input logic c_kill,
                                input logic ready);
      xif.ex_valid_i     = ex_v;
      xif.ex_id_i        = id;
      xif.ex_rd_i        = rd;
      xif.ex_data_i      = data;
      xif.ex_we_i        = we;
      xif.commit_valid_i = c_v;
      xif.commit_id_i    = c_id;
      xif.commit_kill_i  = c_kill;
      xif.result_ready_i = ready;
   endtask

   task automatic idle(input logic ready);
      applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, '0, 1'b0, ready);
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic checkResult(input string tag, input logic v, input logic [ID_WIDTH-1:0] id,
                              input logic [4:0] rd, input logic [DATA_WIDTH-1:0] data, input logic we);
      checkOutput({tag, ".valid"}, 64'(xif.result_valid_o), 64'(v));
      checkOutput({tag, ".id"},    64'(xif.result_id_o),    64'(id));
      checkOutput({tag, ".rd"},    64'(xif.result_rd_o),    64'(rd));
      checkOutput({tag, ".data"},  64'(xif.result_data_o),  64'(data));
      checkOutput({tag, ".we"},    64'(xif.result_we_o),    64'(we));
   endtask

   task automatic checkCount(input string tag, input int cnt, input logic rdy);
      checkOutput({tag, ".count"},    64'(xif.count_o),    64'(cnt));
      checkOutput({tag, ".ex_ready"}, 64'(xif.ex_ready_o), 64'(rdy));
   endtask

   initial begin
      rst = 1'b1;
      idle(1'b0);
      settle();
      checkResult("reset", 1'b0, 0, 0, 0, 1'b0);
      checkCount("reset", 0, 1'b1);
      nextCycle();
      rst = 1'b0;

      // Commit first, then the result: presented the cycle after the push and popped at once.
      applyStimulus(1'b0, 0, 0, 0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b1);
      settle(); checkResult("t1.pre", 1'b0, 0, 0, 0, 1'b0);
      nextCycle();
      applyStimulus(1'b1, 4'd3, 5'd5, 32'hDEADBEEF, 1'b1, 1'b0, 0, 1'b0, 1'b1);
      settle(); checkResult("t1.push", 1'b0, 0, 0, 0, 1'b0); checkCount("t1.push", 0, 1'b1);
      nextCycle();
      idle(1'b1);
      settle(); checkResult("t1.out", 1'b1, 4'd3, 5'd5, 32'hDEADBEEF, 1'b1); checkCount("t1.out", 1, 1'b1);
      nextCycle();
      settle(); checkResult("t1.after", 1'b0, 0, 0, 0, 1'b0); checkCount("t1.after", 0, 1'b1);

      // Out-of-order commits still release results in push order.
      nextCycle();
      applyStimulus(1'b1, 4'd1, 5'd1, 32'h11, 1'b1, 1'b0, 0, 1'b0, 1'b1); nextCycle();
      applyStimulus(1'b1, 4'd2, 5'd2, 32'h22, 1'b1, 1'b0, 0, 1'b0, 1'b1); nextCycle();
      applyStimulus(1'b1, 4'd3, 5'd3, 32'h33, 1'b0, 1'b0, 0, 1'b0, 1'b1); nextCycle();
      applyStimulus(1'b0, 0, 0, 0, 1'b0, 1'b1, 4'd2, 1'b0, 1'b1);
      settle(); checkResult("t2.c2", 1'b0, 0, 0, 0, 1'b0); checkCount("t2.c2", 3, 1'b1);
      nextCycle();
      applyStimulus(1'b0, 0, 0, 0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b1);
      settle(); checkResult("t2.c1", 1'b0, 0, 0, 0, 1'b0);
      nextCycle();
      applyStimulus(1'b0, 0, 0, 0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b1);
      settle(); checkResult("t2.r1", 1'b1, 4'd1, 5'd1, 32'h11, 1'b1);
      nextCycle();
      idle(1'b1);
      settle(); checkResult("t2.r2", 1'b1, 4'd2, 5'd2, 32'h22, 1'b1);
      nextCycle();
      settle(); checkResult("t2.r3", 1'b1, 4'd3, 5'd3, 32'h33, 1'b0);
      nextCycle();
      settle(); checkResult("t2.end", 1'b0, 0, 0, 0, 1'b0); checkCount("t2.end", 0, 1'b1);

      // Killed head is dropped silently; the next committed entry follows right after.
      nextCycle();
      applyStimulus(1'b1, 4'd4, 5'd4, 32'h44, 1'b1, 1'b0, 0, 1'b0, 1'b1); nextCycle();
      applyStimulus(1'b1, 4'd5, 5'd6, 32'h55, 1'b1, 1'b0, 0, 1'b0, 1'b1); nextCycle();
      applyStimulus(1'b0, 0, 0, 0, 1'b0, 1'b1, 4'd4, 1'b1, 1'b1);
      settle(); checkResult("t3.k4", 1'b0, 0, 0, 0, 1'b0);
      nextCycle();
      applyStimulus(1'b0, 0, 0, 0, 1'b0, 1'b1, 4'd5, 1'b0, 1'b1);
      settle(); checkResult("t3.drop", 1'b0, 0, 0, 0, 1'b0); checkCount("t3.drop", 2, 1'b1);
      nextCycle();
      idle(1'b1);
      settle(); checkResult("t3.r5", 1'b1, 4'd5, 5'd6, 32'h55, 1'b1); checkCount("t3.r5", 1, 1'b1);
      nextCycle();
      settle(); checkCount("t3.end", 0, 1'b1);

      // Fill to DEPTH with everything committed and the consumer stalled.
      nextCycle();
      for (int k = 8; k < 12; k++) begin
         applyStimulus(1'b1, 4'(k), 5'(k + 10), 32'hA000_0000 + 32'(k), 1'b1, 1'b1, 4'(k), 1'b0, 1'b0);
         nextCycle();
      end
      for (int c = 0; c < 3; c++) begin
         applyStimulus(1'b1, 4'd12, 5'd12, 32'hC, 1'b1, 1'b0, 0, 1'b0, 1'b0);
         settle(); checkResult("t4.hold", 1'b1, 4'd8, 5'd18, 32'hA000_0008, 1'b1); checkCount("t4.hold", 4, 1'b0);
         nextCycle();
      end
      applyStimulus(1'b1, 4'd12, 5'd12, 32'hC, 1'b1, 1'b0, 0, 1'b0, 1'b1);
      settle(); checkResult("t4.pop8", 1'b1, 4'd8, 5'd18, 32'hA000_0008, 1'b1); checkCount("t4.pop8", 4, 1'b0);
      nextCycle();
      settle(); checkResult("t4.pop9", 1'b1, 4'd9, 5'd19, 32'hA000_0009, 1'b1); checkCount("t4.pop9", 3, 1'b1);
      nextCycle();
      idle(1'b1);
      settle(); checkResult("t4.pop10", 1'b1, 4'd10, 5'd20, 32'hA000_000A, 1'b1); checkCount("t4.pop10", 3, 1'b1);
      nextCycle();
      settle(); checkResult("t4.pop11", 1'b1, 4'd11, 5'd21, 32'hA000_000B, 1'b1); checkCount("t4.pop11", 2, 1'b1);
      nextCycle();
      applyStimulus(1'b0, 0, 0, 0, 1'b0, 1'b1, 4'd12, 1'b1, 1'b1);
      settle(); checkResult("t4.wait12", 1'b0, 0, 0, 0, 1'b0); checkCount("t4.wait12", 1, 1'b1);
      nextCycle();
      idle(1'b1);
      settle(); checkResult("t4.drop12", 1'b0, 0, 0, 0, 1'b0);
      nextCycle();
      settle(); checkCount("t4.end", 0, 1'b1);

      // Reset with two committed entries queued.
      nextCycle();
      applyStimulus(1'b1, 4'd1, 5'd1, 32'h1111, 1'b1, 1'b1, 4'd1, 1'b0, 1'b0); nextCycle();
      applyStimulus(1'b1, 4'd2, 5'd2, 32'h2222, 1'b1, 1'b1, 4'd2, 1'b0, 1'b0); nextCycle();
      idle(1'b0);
      settle(); checkResult("t5.pre", 1'b1, 4'd1, 5'd1, 32'h1111, 1'b1); checkCount("t5.pre", 2, 1'b1);
      nextCycle();
      rst = 1'b1;
      settle(); checkResult("t5.rst", 1'b0, 0, 0, 0, 1'b0); checkCount("t5.rst", 0, 1'b1);
      nextCycle();
      settle(); checkResult("t5.rst2", 1'b0, 0, 0, 0, 1'b0); checkCount("t5.rst2", 0, 1'b1);
      nextCycle();
      rst = 1'b0;
      applyStimulus(1'b1, 4'd1, 5'd1, 32'h1111, 1'b1, 1'b0, 0, 1'b0, 1'b1); nextCycle();
      applyStimulus(1'b1, 4'd2, 5'd2, 32'h2222, 1'b1, 1'b0, 0, 1'b0, 1'b1); nextCycle();
      idle(1'b1);
      settle(); checkResult("t5.stale", 1'b0, 0, 0, 0, 1'b0); checkCount("t5.stale", 2, 1'b1);
      nextCycle();
      applyStimulus(1'b0, 0, 0, 0, 1'b0, 1'b1, 4'd1, 1'b1, 1'b1);
      settle(); checkResult("t5.stale2", 1'b0, 0, 0, 0, 1'b0);
      nextCycle();
      applyStimulus(1'b0, 0, 0, 0, 1'b0, 1'b1, 4'd2, 1'b1, 1'b1);
      settle(); checkCount("t5.k1", 2, 1'b1);
      nextCycle();
      idle(1'b1);
      settle(); checkCount("t5.k2", 1, 1'b1);
      nextCycle();
      settle(); checkCount("t5.end", 0, 1'b1);

      // Killed id 7 is dropped in the same cycle a fresh commit for id 7 arrives.
      nextCycle();
      applyStimulus(1'b1, 4'd7, 5'd7, 32'h77, 1'b1, 1'b0, 0, 1'b0, 1'b1); nextCycle();
      applyStimulus(1'b0, 0, 0, 0, 1'b0, 1'b1, 4'd7, 1'b1, 1'b1); nextCycle();
      applyStimulus(1'b0, 0, 0, 0, 1'b0, 1'b1, 4'd7, 1'b0, 1'b1);
      settle(); checkResult("t6.drop", 1'b0, 0, 0, 0, 1'b0); checkCount("t6.drop", 1, 1'b1);
      nextCycle();
      idle(1'b1);
      settle(); checkCount("t6.empty", 0, 1'b1);
      nextCycle();
      applyStimulus(1'b1, 4'd7, 5'd8, 32'h7777, 1'b1, 1'b0, 0, 1'b0, 1'b1);
      settle(); checkResult("t6.push", 1'b0, 0, 0, 0, 1'b0);
      nextCycle();
      idle(1'b1);
      settle(); checkResult("t6.out", 1'b1, 4'd7, 5'd8, 32'h7777, 1'b1);
      nextCycle();
      settle(); checkResult("t6.end", 1'b0, 0, 0, 0, 1'b0); checkCount("t6.end", 0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/xif_result_stage.md
Name: xif_result_stage

Overview:
- Writeback stage directly downstream of the custom execute stage in the coprocessor.
- Buffers executed results in order and matches each result against the X-IF commit stream by instruction id.
- Presents committed, non-killed results on the X-IF result channel with valid/ready handshake.
- Silently drops killed results.

Parameters:
DEPTH, 4, result FIFO entries; power of two, ≥2
ID_WIDTH, 4, width of X-IF instruction id
DATA_WIDTH, 32, result data width

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active-high
ex_valid_i  in  1  execute stage has a result this cycle
ex_ready_o  out  1  stage can accept a result
ex_id_i  in  ID_WIDTH  id of executed instruction
ex_rd_i  in  5  destination register
ex_data_i  in  DATA_WIDTH  result value
ex_we_i  in  1  result writes rd
commit_valid_i  in  1  X-IF commit transaction
commit_id_i  in  ID_WIDTH  id being committed/killed
commit_kill_i  in  1  1 = kill, 0 = commit
result_valid_o  out  1  X-IF result_valid
result_ready_i  in  1  X-IF result_ready
result_id_o  out  ID_WIDTH  X-IF result.id
result_rd_o  out  5  X-IF result.rd
result_data_o  out  DATA_WIDTH  X-IF result.data
result_we_o  out  1  X-IF result.we
count_o  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst_i high, async): wr/rd pointers and count cleared, commit table cleared. result_valid_o=0, ex_ready_o=1, count_o=0, result_* fields=0. Memory contents are not reset. Reset mid-transfer discards all entries and commit state.
- FIFO: push when ex_valid_i && ex_ready_o. ex_ready_o = !full, with no same-cycle pop-through when full. Pointers wrap modulo DEPTH.
- Commit table: 2**ID_WIDTH entries, each holding {cmt, kill}.
  - commit_valid_i sets cmt[commit_id_i]=1 and kill[commit_id_i]=commit_kill_i at the next edge.
  - Commit may arrive before, with, or after the matching ex result.
  - Table write is visible one cycle later.
- Head evaluation, with h = head entry id:
  - Empty: result_valid_o=0.
  - cmt[h] && !kill[h]: result_valid_o=1, fields driven from head entry.
  - cmt[h] && kill[h]: head dropped at next edge (pop, clear table[h]). result_valid_o stays 0. One drop per cycle.
  - !cmt[h]: wait; result_valid_o=0.
- Handshake: on result_valid_o && result_ready_i, pop and clear table[h].
  - Once asserted, result_valid_o and all fields hold stable until accepted.
  - No combinational path from result_ready_i to result_valid_o.
- result_* fields are forced to 0 whenever result_valid_o=0.
- Same-cycle set and clear of one table entry (id reuse): set wins.
- Simultaneous push and pop (not full): count unchanged, both take effect.
- Latency:
  - Result pushed at edge N with commit already recorded: result_valid_o high in cycle after N.
  - Commit at edge M after push: result_valid_o high after M.
- Protocol errors (repeat commit of a live id, push of an id already in FIFO) are not detected. Behaviour is undefined. Simulation assertion flags them.
- count_o = entries stored, 0..DEPTH.

Test Plan:
1. Commit id 3 (kill=0), then push {id 3, rd 5, data 0xDEADBEEF, we 1}, result_ready_i=1 → result_valid_o one cycle after push with id 3/rd 5/0xDEADBEEF/we 1; popped same cycle; count_o returns to 0.
2. Push ids 1, 2, 3; commit 2 then 1 then 3; result_ready_i=1 → results in order 1, 2, 3; nothing issued before id 1 commits.
3. Push ids 4, 5; kill id 4, commit id 5 → id 4 never shows result_valid_o; id 5 presented the cycle after the drop.
4. Fill DEPTH=4 with ready low and all committed → ex_ready_o=0 with count_o=4. Hold result_ready_i=0 for 3 cycles → outputs stable. Raise ready → one pop per cycle; ex_ready_o=1 after first pop.
5. Assert rst_i mid-stream with 2 entries and pending commits → next cycle result_valid_o=0, count_o=0, ex_ready_o=1; stale commits do not release later pushes of the same ids.
6. Drop id 7 (killed) while new commit for id 7 arrives same cycle; push id 7 later → presented (set-wins rule).
